// File: rtl/hist_equalize_pkg.sv
// Shared definitions for the greyscale histogram path: widths, FSM states and
// the display-word packing used by the histogram and equalisation blocks.
package hist_equalize_pkg;

    localparam int GREY_WIDTH  = 12;
    localparam int COUNT_WIDTH = 20;
    localparam int NUM_BINS    = 256;
    localparam int BIN_IDX_W   = 8;

    typedef enum logic [1:0] {
        LOAD,
        BUILD,
        PEND
    } state_t;

    // Display word: 5-bit field followed by the 10 MSBs of the grey value.
    function automatic logic [15:0] pack_display(input logic [4:0] hi, input logic [9:0] lo);
        return {1'b0, hi, lo};
    endfunction

endpackage

// File: rtl/hist_lut_bank.sv
// Double-buffered equalisation LUT: BUILD writes the inactive bank while the
// pixel path reads the active one; swap flips which bank is active.
module hist_lut_bank
    import hist_equalize_pkg::*;
#(
    parameter int DATA_W = GREY_WIDTH,
    parameter int ADDR_W = BIN_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic bank_sel_reg;
    logic rd_sel_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_reg <= 1'b0;
            rd_sel_reg   <= 1'b0;
        end else begin
            if (swap)
                bank_sel_reg <= ~bank_sel_reg;
            rd_sel_reg <= bank_sel_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [2**ADDR_W];
            logic [DATA_W-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && (bank_sel_reg != 1'(gi)))
                    mem[wr_addr] <= wr_data;
                rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    // Select follows the read by one register so a swap never splits a read.
    assign rd_data = rd_sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q;

endmodule

// File: rtl/hist_equalize.sv
// Histogram-equalisation mapper: loads a 256-bin histogram, builds a CDF LUT
// into the idle bank, swaps on the next frame start and remaps every pixel.
module hist_equalize
    import hist_equalize_pkg::*;
#(
    parameter int GREY_WIDTH  = hist_equalize_pkg::GREY_WIDTH,
    parameter int COUNT_WIDTH = hist_equalize_pkg::COUNT_WIDTH,
    parameter int LOG2_PIXELS = 10,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   iPclk,
    input  logic                   iRST,
    input  logic                   Fval,
    input  logic                   Dval,
    input  logic [GREY_WIDTH-1:0]  Grey,
    input  logic                   iBin_Valid,
    input  logic [7:0]             iBin_Idx,
    input  logic [COUNT_WIDTH-1:0] iBin_Count,
    output logic                   oBin_Ready,
    output logic                   oSeq_Err,
    output logic                   oLut_Valid,
    output logic                   oEq_Dval,
    output logic [GREY_WIDTH-1:0]  oEq_Grey,
    output logic [OUT_WIDTH-1:0]   oGr_Out1,
    output logic [OUT_WIDTH-1:0]   oGr_Out2
);

    localparam int SCALE_W = COUNT_WIDTH + 1 + GREY_WIDTH;
    localparam logic [SCALE_W-1:0] LUT_MAX = SCALE_W'((1 << GREY_WIDTH) - 1);

    state_t                 state_reg, state_next;
    logic [BIN_IDX_W-1:0]   exp_idx_reg;
    logic                   seq_err_reg;
    logic [BIN_IDX_W:0]     build_idx_reg;
    logic                   rd_pend_reg;
    logic [BIN_IDX_W-1:0]   rd_idx_reg;
    logic [COUNT_WIDTH-1:0] bin_q_reg;
    logic [COUNT_WIDTH:0]   cum_reg, cum_next;
    logic [SCALE_W-1:0]     scaled;
    logic [GREY_WIDTH-1:0]  lut_wr_data;
    logic                   lut_valid_reg, fval_d_reg;
    logic                   bin_xfer, bin_match, fval_rise, rd_issue, swap;
    logic [COUNT_WIDTH-1:0] bin_ram [NUM_BINS];

    logic [BIN_IDX_W-1:0]   px_addr_reg;
    logic [GREY_WIDTH-1:0]  grey_d1_reg, grey_d2_reg, lut_rd_data;
    logic                   dval_d1_reg, dval_d2_reg, use_lut_reg;

    always_comb begin
        bin_xfer    = iBin_Valid && (state_reg == LOAD);
        bin_match   = (iBin_Idx == exp_idx_reg);
        fval_rise   = Fval && !fval_d_reg;
        rd_issue    = (state_reg == BUILD) && !build_idx_reg[BIN_IDX_W];
        swap        = (state_reg == PEND) && fval_rise;
        cum_next    = cum_reg + {1'b0, bin_q_reg};
        scaled      = ({{GREY_WIDTH{1'b0}}, cum_next} << GREY_WIDTH) >> LOG2_PIXELS;
        lut_wr_data = (scaled > LUT_MAX) ? LUT_MAX[GREY_WIDTH-1:0] : scaled[GREY_WIDTH-1:0];

        state_next = state_reg;
        case (state_reg)
            LOAD:  if (bin_xfer && bin_match && (iBin_Idx == 8'hFF)) state_next = BUILD;
            BUILD: if (rd_pend_reg && (rd_idx_reg == 8'hFF))         state_next = PEND;
            PEND:  if (fval_rise)                                    state_next = LOAD;
            default:                                                 state_next = LOAD;
        endcase
    end

    // Bin storage and its registered read feed the one-cycle write pipeline.
    always_ff @(posedge iPclk) begin
        if (bin_xfer && bin_match)
            bin_ram[iBin_Idx] <= iBin_Count;
        bin_q_reg <= bin_ram[build_idx_reg[BIN_IDX_W-1:0]];
    end

    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) begin
            state_reg     <= LOAD;
            exp_idx_reg   <= '0;
            seq_err_reg   <= 1'b0;
            build_idx_reg <= '0;
            rd_pend_reg   <= 1'b0;
            rd_idx_reg    <= '0;
            cum_reg       <= '0;
            lut_valid_reg <= 1'b0;
            fval_d_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fval_d_reg  <= Fval;
            seq_err_reg <= bin_xfer && !bin_match;
            rd_pend_reg <= rd_issue;
            rd_idx_reg  <= build_idx_reg[BIN_IDX_W-1:0];
            if (bin_xfer)
                exp_idx_reg <= bin_match ? exp_idx_reg + 8'd1 : '0;
            if (state_reg == LOAD) begin
                build_idx_reg <= '0;
                cum_reg       <= '0;
            end else begin
                if (rd_issue)
                    build_idx_reg <= build_idx_reg + 9'd1;
                if (rd_pend_reg)
                    cum_reg <= cum_next;
            end
            if (swap)
                lut_valid_reg <= 1'b1;
        end
    end

    hist_lut_bank #(
        .DATA_W (GREY_WIDTH),
        .ADDR_W (BIN_IDX_W)
    ) u_lut_bank (
        .clk     (iPclk),
        .rst     (iRST),
        .swap    (swap),
        .wr_en   (rd_pend_reg),
        .wr_addr (rd_idx_reg),
        .wr_data (lut_wr_data),
        .rd_addr (px_addr_reg),
        .rd_data (lut_rd_data)
    );

    // The LUT-enable travels with each pixel so a swap lands on a pixel boundary.
    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) begin
            px_addr_reg <= '0;
            grey_d1_reg <= '0;
            grey_d2_reg <= '0;
            dval_d1_reg <= 1'b0;
            dval_d2_reg <= 1'b0;
            use_lut_reg <= 1'b0;
        end else begin
            px_addr_reg <= Grey[GREY_WIDTH-1 -: BIN_IDX_W];
            grey_d1_reg <= Grey;
            dval_d1_reg <= Dval;
            grey_d2_reg <= grey_d1_reg;
            dval_d2_reg <= dval_d1_reg;
            use_lut_reg <= lut_valid_reg;
        end
    end

    assign oBin_Ready = (state_reg == LOAD);
    assign oSeq_Err   = seq_err_reg;
    assign oLut_Valid = lut_valid_reg;
    assign oEq_Dval   = dval_d2_reg;
    assign oEq_Grey   = use_lut_reg ? lut_rd_data : grey_d2_reg;
    assign oGr_Out1   = OUT_WIDTH'(pack_display(oEq_Grey[GREY_WIDTH-1 -: 5], oEq_Grey[GREY_WIDTH-1 -: 10]));
    assign oGr_Out2   = OUT_WIDTH'(pack_display(oEq_Grey[GREY_WIDTH-6 -: 5], oEq_Grey[GREY_WIDTH-1 -: 10]));

endmodule
